// File: rtl/dmgplus_splash_gen2.sv
// Splash generator: checks a ROM signature, streams a packed BPP-bit image from
// ROM into splash VRAM, holds it for a number of vblanks, then optionally fades it.
module dmgplus_splash_gen2 #(
    parameter int          BPP         = 2,
    parameter int          IMG_W       = 160,
    parameter int          IMG_H       = 144,
    parameter int          SIG_LEN     = 4,
    parameter logic [63:0] SIG         = 64'h444D472B,
    parameter logic [15:0] SIG_ADDR    = 16'h0134,
    parameter logic [15:0] IMG_ADDR    = 16'h4000,
    parameter logic [15:0] VRAM_BASE   = 16'h0000,
    parameter int          HOLD_FRAMES = 60,
    parameter int          FADE_FRAMES = 4
) (
    input  logic           clk_8m,
    input  logic           rst_n,
    input  logic           ena,
    input  logic           in_vblank,
    output logic [15:0]    rom_addr,
    input  logic [7:0]     rom_data,
    output logic           rom_rd,
    input  logic           rom_bsy,
    output logic           vramclk,
    output logic [15:0]    vramaddr,
    output logic [BPP-1:0] vramdata,
    output logic           vramwe,
    output logic [BPP-1:0] fade_level,
    output logic           is_dmgplus,
    output logic           rom_read_done,
    output logic           splash_done
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int PPB  = 8 / BPP;
    localparam int PW   = $clog2(NPIX + 1);
    localparam logic [BPP-1:0] FADE_MAX = '1;

    typedef enum logic [2:0] {S_IDLE, S_SIG, S_IMG, S_PIX, S_HOLD, S_FADE, S_DONE} state_t;

    state_t         state_q;
    logic [2:0]     vb_sync_q;
    logic           vb_edge;
    logic           rom_rd_q, rd_wait_q, rd_capture;
    logic [15:0]    rom_addr_q;
    logic [2:0]     k_q;
    logic [15:0]    b_q;
    logic [PW-1:0]  p_q;
    logic [3:0]     j_q;
    logic [7:0]     pix_byte_q;
    logic [15:0]    frame_q, frame_d;
    logic [7:0]     sig_byte;
    logic [15:0]    vramaddr_q;
    logic [BPP-1:0] vramdata_q, fade_q;
    logic           vramwe_q, is_dmgplus_q, rom_read_done_q, splash_done_q;

    // Two-FF synchroniser plus one delay stage for rising-edge detection.
    assign vb_edge    = vb_sync_q[1] & ~vb_sync_q[2];
    // Frame count including an edge arriving this cycle.
    assign frame_d    = frame_q + {15'd0, vb_edge};
    assign sig_byte   = 8'(SIG >> (8 * (SIG_LEN - 1 - int'(k_q))));
    assign rd_capture = rd_wait_q & ~rom_bsy;

    // rom_rd drops combinationally with ena so an abort releases the bus at once.
    assign rom_rd        = rom_rd_q & ena;
    assign rom_addr      = rom_addr_q;
    assign vramclk       = clk_8m;
    assign vramaddr      = vramaddr_q;
    assign vramdata      = vramdata_q;
    assign vramwe        = vramwe_q;
    assign fade_level    = fade_q;
    assign is_dmgplus    = is_dmgplus_q;
    assign rom_read_done = rom_read_done_q;
    assign splash_done   = splash_done_q;

    // vblank synchroniser shift register.
    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) vb_sync_q <= '0;
        else        vb_sync_q <= {vb_sync_q[1:0], in_vblank};
    end

    // Main sequencer; ena low clears everything back to IDLE (abort or re-arm).
    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n || !ena) begin
            state_q         <= S_IDLE;
            rom_rd_q        <= 1'b0;
            rd_wait_q       <= 1'b0;
            rom_addr_q      <= '0;
            k_q             <= '0;
            b_q             <= '0;
            p_q             <= '0;
            j_q             <= '0;
            pix_byte_q      <= '0;
            frame_q         <= '0;
            vramaddr_q      <= '0;
            vramdata_q      <= '0;
            vramwe_q        <= 1'b0;
            fade_q          <= '0;
            is_dmgplus_q    <= 1'b0;
            rom_read_done_q <= 1'b0;
            splash_done_q   <= 1'b0;
        end else begin
            vramwe_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    state_q    <= S_SIG;
                    k_q        <= '0;
                    rom_addr_q <= SIG_ADDR;
                    rom_rd_q   <= 1'b1;
                end
                S_SIG, S_IMG: begin
                    if (rom_rd_q && rom_bsy) begin
                        rom_rd_q  <= 1'b0;
                        rd_wait_q <= 1'b1;
                    end else if (rd_capture) begin
                        rd_wait_q <= 1'b0;
                        if (state_q == S_IMG) begin
                            pix_byte_q <= rom_data;
                            j_q        <= '0;
                            state_q    <= S_PIX;
                        end else if (rom_data != sig_byte) begin
                            rom_read_done_q <= 1'b1;
                            splash_done_q   <= 1'b1;
                            state_q         <= S_DONE;
                        end else if (k_q == 3'(SIG_LEN - 1)) begin
                            is_dmgplus_q <= 1'b1;
                            rom_addr_q   <= IMG_ADDR + b_q;
                            rom_rd_q     <= 1'b1;
                            state_q      <= S_IMG;
                        end else begin
                            k_q        <= k_q + 3'd1;
                            rom_addr_q <= SIG_ADDR + 16'(k_q) + 16'd1;
                            rom_rd_q   <= 1'b1;
                        end
                    end
                end
                S_PIX: begin
                    vramwe_q   <= 1'b1;
                    vramaddr_q <= VRAM_BASE + 16'(p_q);
                    vramdata_q <= pix_byte_q[BPP-1:0];
                    pix_byte_q <= pix_byte_q >> BPP;
                    j_q        <= j_q + 4'd1;
                    p_q        <= p_q + 1'b1;
                    if (p_q == PW'(NPIX - 1)) begin
                        frame_q <= 16'(vb_edge);
                        state_q <= S_HOLD;
                    end else if (j_q == 4'(PPB - 1)) begin
                        b_q        <= b_q + 16'd1;
                        rom_addr_q <= IMG_ADDR + b_q + 16'd1;
                        rom_rd_q   <= 1'b1;
                        state_q    <= S_IMG;
                    end
                end
                S_HOLD: begin
                    // Lands one cycle after the final pixel write becomes visible.
                    rom_read_done_q <= 1'b1;
                    if (frame_d >= 16'(HOLD_FRAMES)) begin
                        frame_q <= frame_d - 16'(HOLD_FRAMES);
                        if (FADE_FRAMES > 0) begin
                            state_q <= S_FADE;
                        end else begin
                            splash_done_q <= 1'b1;
                            state_q       <= S_DONE;
                        end
                    end else begin
                        frame_q <= frame_d;
                    end
                end
                S_FADE: begin
                    if (frame_d >= 16'(FADE_FRAMES)) begin
                        frame_q <= frame_d - 16'(FADE_FRAMES);
                        fade_q  <= fade_q + 1'b1;
                        if (fade_q == FADE_MAX - 1'b1) begin
                            splash_done_q <= 1'b1;
                            state_q       <= S_DONE;
                        end
                    end else begin
                        frame_q <= frame_d;
                    end
                end
                default: ;  // S_DONE: hold everything until ena drops
            endcase
        end
    end
endmodule

// File: tb/tb_dmgplus_splash_gen2.sv
// Self-checking bench: two configurations (BPP=2 8x2 with fade, BPP=8 4x1 no fade),
// a scenario table plus directed reset / timing / fade / abort sequences.
module tb_dmgplus_splash_gen2;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    // ---------------- DUT A: BPP=2, 8x2, HOLD=3, FADE=2
    logic        ena_a, vb_a, rd_a, bsy_a, vclk_a, we_a, dmg_a, rrd_a, sd_a;
    logic [15:0] addr_a, vaddr_a;
    logic [7:0]  data_a;
    logic [1:0]  vdata_a, fade_a;
    dmgplus_splash_gen2 #(.BPP(2), .IMG_W(8), .IMG_H(2), .HOLD_FRAMES(3), .FADE_FRAMES(2)) dut_a (
        .clk_8m(clk), .rst_n(rst_n), .ena(ena_a), .in_vblank(vb_a),
        .rom_addr(addr_a), .rom_data(data_a), .rom_rd(rd_a), .rom_bsy(bsy_a),
        .vramclk(vclk_a), .vramaddr(vaddr_a), .vramdata(vdata_a), .vramwe(we_a),
        .fade_level(fade_a), .is_dmgplus(dmg_a), .rom_read_done(rrd_a), .splash_done(sd_a));

    // ---------------- DUT B: BPP=8, 4x1, HOLD=2, no fade
    logic        ena_b, vb_b, rd_b, bsy_b, vclk_b, we_b, dmg_b, rrd_b, sd_b;
    logic [15:0] addr_b, vaddr_b;
    logic [7:0]  data_b, vdata_b, fade_b;
    dmgplus_splash_gen2 #(.BPP(8), .IMG_W(4), .IMG_H(1), .HOLD_FRAMES(2), .FADE_FRAMES(0)) dut_b (
        .clk_8m(clk), .rst_n(rst_n), .ena(ena_b), .in_vblank(vb_b),
        .rom_addr(addr_b), .rom_data(data_b), .rom_rd(rd_b), .rom_bsy(bsy_b),
        .vramclk(vclk_b), .vramaddr(vaddr_b), .vramdata(vdata_b), .vramwe(we_b),
        .fade_level(fade_b), .is_dmgplus(dmg_b), .rom_read_done(rrd_b), .splash_done(sd_b));

    // ---------------- ROM contents: mode 0 = no signature, 1 = "DMG+", 2 = last sig byte wrong
    int         mode_a = 0, mode_b = 1;
    bit         rnd_lat_a = 0;
    logic [7:0] img_a [256];
    logic [7:0] img_b [256];

    function automatic logic [7:0] rom_val(bit which, logic [15:0] a);
        logic [31:0] sig;
        int          m, off;
        sig = 32'h444D472B;
        m   = which ? mode_b : mode_a;
        off = int'(a) - 32'h4000;
        if (m != 0 && a >= 16'h0134 && a <= 16'h0137) begin
            if (m == 2 && a == 16'h0137) return 8'h2A;
            return 8'(sig >> (8 * (3 - (int'(a) - 32'h134))));
        end
        if (off >= 0 && off < 256) return which ? img_b[off] : img_a[off];
        return a[7:0];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- ROM responders (drive at negedge)
    logic [15:0] reads_a[$], reads_b[$];
    logic [15:0] ra, rb_addr;
    initial begin
        bsy_a = 1'b0; data_a = 8'h00;
        forever begin
            @(negedge clk);
            if (rd_a) begin
                ra = addr_a;
                repeat (rnd_lat_a ? $urandom_range(0, 2) : 0) @(negedge clk);
                reads_a.push_back(ra);
                bsy_a = 1'b1;
                repeat (rnd_lat_a ? $urandom_range(1, 3) : 1) @(negedge clk);
                data_a = rom_val(1'b0, ra);
                bsy_a  = 1'b0;
            end
        end
    end
    initial begin
        bsy_b = 1'b0; data_b = 8'h00;
        forever begin
            @(negedge clk);
            if (rd_b) begin
                rb_addr = addr_b;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                reads_b.push_back(rb_addr);
                bsy_b = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                data_b = rom_val(1'b1, rb_addr);
                bsy_b  = 1'b0;
            end
        end
    end

    // ---------------- vblank sources
    logic vb_gen_a = 1'b0, vb_man_a = 1'b0, vb_auto_a = 1'b0, vb_gen_b = 1'b0;
    assign vb_a = vb_auto_a ? vb_gen_a : vb_man_a;
    assign vb_b = vb_gen_b;
    initial forever begin
        vb_gen_a = 1'b1; repeat ($urandom_range(1, 4)) @(negedge clk);
        vb_gen_a = 1'b0; repeat ($urandom_range(3, 10)) @(negedge clk);
    end
    initial forever begin
        vb_gen_b = 1'b1; repeat ($urandom_range(1, 4)) @(negedge clk);
        vb_gen_b = 1'b0; repeat ($urandom_range(3, 10)) @(negedge clk);
    end

    // ---------------- write / status monitors
    logic [15:0] wa_addr[$], wb_addr[$];
    logic [7:0]  wa_data[$], wb_data[$];
    int   last_we_a = -1, rrd_cyc_a = -1;
    logic rrd_prev_a = 1'b0, rrd_prev_b = 1'b0, sd_at_rrd_b = 1'b1;
    initial forever begin
        @(negedge clk);
        if (we_a) begin
            wa_addr.push_back(vaddr_a); wa_data.push_back(8'(vdata_a)); last_we_a = cyc;
        end
        if (rrd_a && !rrd_prev_a) rrd_cyc_a = cyc;
        rrd_prev_a = rrd_a;
        if (we_b) begin
            wb_addr.push_back(vaddr_b); wb_data.push_back(vdata_b);
        end
        if (rrd_b && !rrd_prev_b) sd_at_rrd_b = sd_b;
        rrd_prev_b = rrd_b;
    end

    // Expected ROM address of the i-th read of a successful (or failing) run.
    function automatic logic [31:0] exp_read(int i);
        return (i < 4) ? 32'h134 + i : 32'h4000 + i - 4;
    endfunction

    // Reference pixel p for DUT A: 4 pixels per byte, LSB first.
    function automatic logic [31:0] pix_a(int p);
        logic [7:0] byt;
        byt = rom_val(1'b0, 16'(32'h4000 + p / 4));
        return 32'((byt >> ((p % 4) * 2)) & 8'h03);
    endfunction

    task automatic check_zero_a(string tag);
        chk({tag, "_rd"}, rd_a, 0);     chk({tag, "_addr"}, addr_a, 0);
        chk({tag, "_we"}, we_a, 0);     chk({tag, "_vaddr"}, vaddr_a, 0);
        chk({tag, "_vdata"}, vdata_a, 0); chk({tag, "_fade"}, fade_a, 0);
        chk({tag, "_dmg"}, dmg_a, 0);   chk({tag, "_rrd"}, rrd_a, 0);
        chk({tag, "_sd"}, sd_a, 0);
    endtask

    typedef struct {
        int mode; bit rand_img; bit rand_lat;
        bit exp_dmg; int exp_reads; int exp_writes;
    } scen_t;
    scen_t tbl[5];

    task automatic run_a(scen_t s);
        int rb, wb;
        ena_a = 1'b0;
        repeat (4) @(negedge clk);
        mode_a = s.mode; rnd_lat_a = s.rand_lat; vb_auto_a = 1'b1;
        for (int i = 0; i < 256; i++) img_a[i] = s.rand_img ? 8'($urandom) : 8'(i);
        rb = reads_a.size(); wb = wa_addr.size();
        ena_a = 1'b1;
        for (int t = 0; t < 5000 && !sd_a; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("tbl_sd", sd_a, 1);
        chk("tbl_dmg", dmg_a, s.exp_dmg);
        chk("tbl_rrd", rrd_a, 1);
        chk("tbl_fade", fade_a, s.exp_dmg ? 3 : 0);
        chk("tbl_nreads", reads_a.size() - rb, s.exp_reads);
        for (int i = 0; i < s.exp_reads && rb + i < reads_a.size(); i++)
            chk("tbl_raddr", reads_a[rb + i], exp_read(i));
        chk("tbl_nwrites", wa_addr.size() - wb, s.exp_writes);
        for (int p = 0; p < s.exp_writes && wb + p < wa_addr.size(); p++) begin
            chk("tbl_vaddr", wa_addr[wb + p], p);
            chk("tbl_vdata", wa_data[wb + p], pix_a(p));
        end
    endtask

    initial begin
        int rb, wb, found;
        logic [31:0] exp_d3 [16];
        exp_d3 = '{0,0,0,0, 1,0,0,0, 2,0,0,0, 3,0,0,0};
        tbl[0] = '{0, 1'b0, 1'b0, 1'b0, 1, 0};
        tbl[1] = '{2, 1'b0, 1'b1, 1'b0, 4, 0};
        tbl[2] = '{1, 1'b0, 1'b1, 1'b1, 8, 16};
        tbl[3] = '{1, 1'b1, 1'b1, 1'b1, 8, 16};
        tbl[4] = '{1, 1'b1, 1'b1, 1'b1, 8, 16};
        for (int i = 0; i < 256; i++) begin img_a[i] = 8'(i); img_b[i] = 8'(i); end

        // Reset with ena high: everything held at 0; then first read quickly.
        rst_n = 1'b0; ena_a = 1'b1; ena_b = 1'b0; mode_a = 0;
        repeat (3) @(negedge clk);
        check_zero_a("rst");
        chk("rst_b_we", we_b, 0); chk("rst_b_sd", sd_b, 0);
        rst_n = 1'b1;
        for (int t = 0; t < 2 && !rd_a; t++) begin @(posedge clk); #1; end
        chk("rst_first_rd", rd_a, 1);
        chk("rst_first_addr", addr_a, 16'h0134);
        for (int t = 0; t < 500 && !sd_a; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("mm_nreads", reads_a.size(), 1);
        chk("mm_dmg", dmg_a, 0);
        chk("mm_sd", sd_a, 1);
        chk("mm_nwrites", wa_addr.size(), 0);

        // Scenario table.
        foreach (tbl[i]) run_a(tbl[i]);

        // Full image with fixed timing; rom_read_done one cycle after last write.
        ena_a = 1'b0; repeat (4) @(negedge clk);
        mode_a = 1; rnd_lat_a = 1'b0; vb_auto_a = 1'b0; vb_man_a = 1'b0;
        for (int i = 0; i < 256; i++) img_a[i] = 8'(i);
        rb = reads_a.size(); wb = wa_addr.size();
        ena_a = 1'b1;
        for (int t = 0; t < 2000 && !rrd_a; t++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("img_nwrites", wa_addr.size() - wb, 16);
        for (int p = 0; p < 16 && wb + p < wa_addr.size(); p++)
            chk("img_vdata", wa_data[wb + p], exp_d3[p]);
        chk("img_nreads", reads_a.size() - rb, 8);
        chk("img_rrd_timing", rrd_cyc_a - last_we_a, 1);
        chk("img_fade0", fade_a, 0);
        chk("img_sd0", sd_a, 0);

        // Hold 3 edges, then fade every 2: levels 1,2,3 on edges 5,7,9.
        for (int e = 1; e <= 9; e++) begin
            vb_man_a = 1'b1; repeat (e == 2 ? 20 : 3) @(negedge clk);
            vb_man_a = 1'b0; repeat (4) @(negedge clk);
            chk($sformatf("fade_e%0d", e), fade_a, (e >= 9) ? 3 : (e >= 7) ? 2 : (e >= 5) ? 1 : 0);
            chk($sformatf("sd_e%0d", e), sd_a, (e == 9) ? 1 : 0);
        end

        // Abort during the 2nd image read with rom_bsy high.
        ena_a = 1'b0; repeat (4) @(negedge clk);
        ena_a = 1'b1; found = 0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk); #1;
            if (bsy_a && addr_a == 16'h4001) begin found = 1; break; end
        end
        chk("abort_found", found, 1);
        ena_a = 1'b0; #1;
        chk("abort_rd_now", rd_a, 0);
        @(posedge clk); #1;
        check_zero_a("abort");
        repeat (10) @(negedge clk);
        rb = reads_a.size();
        ena_a = 1'b1;
        for (int t = 0; t < 50 && reads_a.size() == rb; t++) @(negedge clk);
        chk("rearm_addr", (reads_a.size() > rb) ? reads_a[rb] : 16'hFFFF, 16'h0134);

        // DUT B: byte per pixel, no fade.
        for (int r = 0; r < 2; r++) begin
            ena_b = 1'b0; repeat (4) @(negedge clk);
            for (int i = 0; i < 256; i++) img_b[i] = 8'($urandom);
            rb = reads_b.size(); wb = wb_addr.size();
            ena_b = 1'b1;
            for (int t = 0; t < 3000 && !sd_b; t++) @(negedge clk);
            repeat (3) @(negedge clk);
            chk("b_sd", sd_b, 1); chk("b_dmg", dmg_b, 1); chk("b_rrd", rrd_b, 1);
            chk("b_fade", fade_b, 0); chk("b_sd_at_rrd", sd_at_rrd_b, 0);
            chk("b_nreads", reads_b.size() - rb, 8);
            for (int i = 0; i < 8 && rb + i < reads_b.size(); i++)
                chk("b_raddr", reads_b[rb + i], exp_read(i));
            chk("b_nwrites", wb_addr.size() - wb, 4);
            for (int p = 0; p < 4 && wb + p < wb_addr.size(); p++) begin
                chk("b_vaddr", wb_addr[wb + p], p);
                chk("b_vdata", wb_data[wb + p], img_b[p]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
